// File: rtl/ksa.sv
// ARC4 key-scheduling stage: permutes the 256-byte S memory in place with a 24-bit key.
// One read-read-write-write pass over a single-port memory per index, six cycles each.
module ksa (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic [7:0]  addr,
  input  logic [7:0]  rddata,
  output logic [7:0]  wrdata,
  output logic        wren
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_I  = 3'd1,
    LAT_I = 3'd2,
    RD_J  = 3'd3,
    LAT_J = 3'd4,
    WR_I  = 3'd5,
    WR_J  = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  i_r, i_s;
  logic [7:0]  j_r, j_s;
  logic [1:0]  kidx_r, kidx_s;
  logic [7:0]  si_r, si_s;
  logic [7:0]  sj_r, sj_s;
  logic [23:0] key_r, key_s;
  logic [7:0]  addr_r, addr_s;
  logic [7:0]  wrdata_r, wrdata_s;
  logic        wren_r, wren_s;
  logic        rdy_r, rdy_s;

  function automatic logic [7:0] key_byte(input logic [23:0] k, input logic [1:0] idx);
    case (idx)
      2'd0:    key_byte = k[23:16];
      2'd1:    key_byte = k[15:8];
      default: key_byte = k[7:0];
    endcase
  endfunction

  // Next-state and datapath update logic
  always_comb begin
    state_s = state_r;
    i_s     = i_r;
    j_s     = j_r;
    kidx_s  = kidx_r;
    si_s    = si_r;
    sj_s    = sj_r;
    key_s   = key_r;
    case (state_r)
      IDLE: begin
        if (en) begin
          key_s   = key;
          i_s     = 8'd0;
          j_s     = 8'd0;
          kidx_s  = 2'd0;
          state_s = RD_I;
        end else begin
          state_s = IDLE;
        end
      end
      RD_I:  state_s = LAT_I;
      LAT_I: begin
        si_s    = rddata;
        j_s     = j_r + rddata + key_byte(key_r, kidx_r);
        state_s = RD_J;
      end
      RD_J:  state_s = LAT_J;
      LAT_J: begin
        sj_s    = rddata;
        state_s = WR_I;
      end
      WR_I:  state_s = WR_J;
      WR_J: begin
        if (i_r == 8'd255) begin
          state_s = IDLE;
        end else begin
          i_s     = i_r + 8'd1;
          kidx_s  = (kidx_r == 2'd2) ? 2'd0 : kidx_r + 2'd1;
          state_s = RD_I;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they appear registered in that state
  always_comb begin
    addr_s   = addr_r;
    wrdata_s = wrdata_r;
    wren_s   = 1'b0;
    rdy_s    = 1'b0;
    case (state_s)
      IDLE: rdy_s = 1'b1;
      RD_I: addr_s = i_s;
      RD_J: addr_s = j_s;
      WR_I: begin
        addr_s   = i_s;
        wrdata_s = sj_s;
        wren_s   = 1'b1;
      end
      WR_J: begin
        addr_s   = j_s;
        wrdata_s = si_s;
        wren_s   = 1'b1;
      end
      LAT_I, LAT_J: wren_s = 1'b0;
      default: begin
        wren_s = 1'b0;
        rdy_s  = 1'b0;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      i_r      <= 8'd0;
      j_r      <= 8'd0;
      kidx_r   <= 2'd0;
      si_r     <= 8'd0;
      sj_r     <= 8'd0;
      key_r    <= 24'd0;
      addr_r   <= 8'd0;
      wrdata_r <= 8'd0;
      wren_r   <= 1'b0;
      rdy_r    <= 1'b1;
    end else begin
      state_r  <= state_s;
      i_r      <= i_s;
      j_r      <= j_s;
      kidx_r   <= kidx_s;
      si_r     <= si_s;
      sj_r     <= sj_s;
      key_r    <= key_s;
      addr_r   <= addr_s;
      wrdata_r <= wrdata_s;
      wren_r   <= wren_s;
      rdy_r    <= rdy_s;
    end
  end

  assign addr   = addr_r;
  assign wrdata = wrdata_r;
  assign wren   = wren_r;
  assign rdy    = rdy_r;

endmodule

// File: tb/tb_ksa.sv
// Directed self-checking bench for ksa: models the single-port S memory, logs every write,
// and compares against hand-computed write pairs and a software key-schedule model.
module tb_ksa;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        rdy;
  logic [23:0] key;
  logic [7:0]  addr;
  logic [7:0]  rddata;
  logic [7:0]  wrdata;
  logic        wren;

  int checks = 0;
  int errors = 0;

  logic [7:0]  mem [256];
  logic        init_req = 1'b0;
  logic [15:0] wlog [8192];
  int          wcnt = 0;
  logic [7:0]  exp_s [256];

  localparam logic [23:0] KEY_A = 24'h00033C;

  ksa dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (en),
    .rdy    (rdy),
    .key    (key),
    .addr   (addr),
    .rddata (rddata),
    .wrdata (wrdata),
    .wren   (wren)
  );

  always #5 clk = ~clk;

  // Synchronous-read single-port memory with identity preload and a write log
  always @(posedge clk) begin
    rddata <= mem[addr];
    if (init_req) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
    end else if (wren) begin
      mem[addr] <= wrdata;
    end
    if (wren && wcnt < 8192) begin
      wlog[wcnt] <= {addr, wrdata};
      wcnt       <= wcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic init_s();
    @(negedge clk);
    init_req = 1'b1;
    @(negedge clk);
    init_req = 1'b0;
  endtask

  task automatic start(input logic [23:0] k);
    @(negedge clk);
    key = k;
    en  = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (1) begin
      @(negedge clk);
      if (rdy === 1'b1) break;
      cyc++;
      if (cyc > 4000) break;
    end
  endtask

  task automatic model(input logic [23:0] k);
    logic [7:0] j, t, kb;
    for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
    j = 8'd0;
    for (int i = 0; i < 256; i++) begin
      case (i % 3)
        0:       kb = k[23:16];
        1:       kb = k[15:8];
        default: kb = k[7:0];
      endcase
      j = j + exp_s[i] + kb;
      t = exp_s[i];
      exp_s[i] = exp_s[j];
      exp_s[j] = t;
    end
  endtask

  task automatic compare_s(input string tag);
    int bad;
    logic [255:0] seen;
    bad  = 0;
    seen = '0;
    for (int k = 0; k < 256; k++) begin
      if (mem[k] !== exp_s[k]) bad++;
      seen[mem[k]] = 1'b1;
    end
    check({tag, "_bytes"}, 32'(bad), 32'd0);
    check({tag, "_perm"}, 32'($countones(seen)), 32'd256);
  endtask

  initial begin
    int base, bad, cyc;
    logic [15:0] exp2 [6];
    logic [15:0] exp3 [8];
    exp2 = '{16'h0001, 16'h0100, 16'h0103, 16'h0300, 16'h0208, 16'h0802};
    exp3 = '{16'h0000, 16'h0000, 16'h0101, 16'h0101, 16'h0203, 16'h0302, 16'h0305, 16'h0502};
    rst_n = 1'b1;
    en    = 1'b0;
    key   = 24'd0;

    // 1: asynchronous reset mid-cycle, then idle
    #3 rst_n = 1'b0;
    #1;
    check("rst_rdy", 32'(rdy), 32'd1);
    check("rst_wren", 32'(wren), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_wrdata", 32'(wrdata), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = wcnt;
    bad  = 0;
    repeat (20) begin
      @(negedge clk);
      if (rdy !== 1'b1 || wren !== 1'b0) bad++;
    end
    check("idle_bad_cycles", 32'(bad), 32'd0);
    check("idle_writes", 32'(wcnt - base), 32'd0);

    // 2: key 010203 first three swaps
    init_s();
    start(24'h010203);
    base = wcnt;
    wait_done(cyc);
    check("k010203_cycles", 32'(cyc), 32'd1536);
    for (int k = 0; k < 6; k++) check($sformatf("k010203_wr%0d", k), 32'(wlog[base + k]), 32'(exp2[k]));
    model(24'h010203);
    compare_s("k010203");

    // 3: zero key, j==i on the first two iterations
    init_s();
    start(24'h000000);
    base = wcnt;
    wait_done(cyc);
    for (int k = 0; k < 8; k++) check($sformatf("k0_wr%0d", k), 32'(wlog[base + k]), 32'(exp3[k]));
    model(24'h000000);
    compare_s("k0");

    // 4: full run against the software model
    model(KEY_A);
    init_s();
    start(KEY_A);
    base = wcnt;
    wait_done(cyc);
    check("full_cycles", 32'(cyc), 32'd1536);
    check("full_writes", 32'(wcnt - base), 32'd512);
    compare_s("full");

    // 5a: en held high restarts only after rdy returns
    init_s();
    @(negedge clk);
    key = KEY_A;
    en  = 1'b1;
    @(posedge clk);
    #1 base = wcnt;
    wait_done(cyc);
    check("hold_cycles", 32'(cyc), 32'd1536);
    check("hold_writes", 32'(wcnt - base), 32'd512);
    compare_s("hold");
    @(negedge clk);
    check("hold_restart_rdy", 32'(rdy), 32'd0);
    en = 1'b0;
    wait_done(cyc);
    check("hold_second_cycles", 32'(cyc), 32'd1535);

    // 5b: en toggling and key changes mid-run are ignored
    init_s();
    start(KEY_A);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      en  = ~en;
      key = 24'hABCDEF ^ 24'(k);
    end
    en = 1'b0;
    wait_done(cyc);
    check("toggle_cycles", 32'(cyc + 100), 32'd1536);
    compare_s("toggle");

    // 6: reset at cycle 700 aborts; a fresh run still gives the reference result
    init_s();
    start(KEY_A);
    repeat (700) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rdy", 32'(rdy), 32'd1);
    check("midrst_wren", 32'(wren), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    init_s();
    start(KEY_A);
    wait_done(cyc);
    check("after_rst_cycles", 32'(cyc), 32'd1536);
    compare_s("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
